proc_ctrl_fsm: RTL and testbench

Multicycle control unit that sequences the processor datapath (register file plus add/sub ALU) one instruction at a time. It accepts an instruction (op_code, rs1, rs2, rd, immediate) over a valid/ready handshake, latches it, and steps through read, execute and write-back. It drives the register-file addresses, write enable, ALU mode and write-data mux select, then reports completion or an illegal opcode. It sits between the instruction source (testbench or future fetch unit) and the processor datapath.

---
 rtl/proc_ctrl_fsm.sv | 170 +++++++++++++++++
 tb/tb_proc_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_fsm.sv
// Multicycle control unit: accepts one instruction at a time and sequences the
// register file / add-sub ALU datapath through read, execute and write-back.
module proc_ctrl_fsm #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // Handshake: an instruction transfers on a rising edge where instr_valid
   // and instr_ready are both 1; at any other edge the inputs are ignored.
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [6:0]        op_code,
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0] imm,
   output logic [ADDR_W-1:0] rf_raddr1,
   output logic [ADDR_W-1:0] rf_raddr2,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic              rf_we,
   output logic              wdata_sel,
   output logic              alu_sub,
   output logic [DATA_W-1:0] imm_out,
   output logic              busy,
   output logic              op_done,
   output logic              illegal_op,
   output logic [CNT_W-1:0]  retired_cnt,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [6:0] OP_NOP   = 7'd0;
   localparam logic [6:0] OP_STORE = 7'd1;
   localparam logic [6:0] OP_ADD   = 7'd2;
   localparam logic [6:0] OP_SUB   = 7'd3;

   state_t            state_q, state_d;
   logic [6:0]        op_q, op_d;
   logic [ADDR_W-1:0] rs1_q, rs1_d;
   logic [ADDR_W-1:0] rs2_q, rs2_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              op_legal;
   logic              is_store;
   logic              is_sub;
   logic [ADDR_W-1:0] wr_addr;

   // Legal opcodes are exactly 0..3, i.e. every upper bit clear.
   assign op_legal = (op_q[6:2] == 5'd0);
   assign is_store = (op_q == OP_STORE);
   assign is_sub   = (op_q == OP_SUB);
   assign wr_addr  = is_store ? rs1_q : rd_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         imm_q   <= imm_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      imm_d   = imm_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d  = op_code;
               rs1_d = rs1;
               rs2_d = rs2;
               rd_d  = rd;
               imm_d = imm;
               case (op_code)
                  OP_ADD, OP_SUB: state_d = S_READ;
                  OP_STORE:       state_d = S_WRITE;
                  default:        state_d = S_DONE;
               endcase
            end
         end
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WRITE;
         S_WRITE: state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
            if (op_legal && !(&cnt_q)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = 1'b0;
      busy        = 1'b0;
      rf_raddr1   = '0;
      rf_raddr2   = '0;
      rf_waddr    = '0;
      rf_we       = 1'b0;
      wdata_sel   = 1'b0;
      alu_sub     = 1'b0;
      op_done     = 1'b0;
      illegal_op  = 1'b0;
      case (state_q)
         S_IDLE: instr_ready = 1'b1;
         S_READ: begin
            busy      = 1'b1;
            rf_raddr1 = rs1_q;
            rf_raddr2 = rs2_q;
         end
         S_EXEC: begin
            busy      = 1'b1;
            rf_raddr1 = rs1_q;
            rf_raddr2 = rs2_q;
            alu_sub   = is_sub;
         end
         S_WRITE: begin
            busy      = 1'b1;
            rf_raddr1 = rs1_q;
            rf_raddr2 = rs2_q;
            rf_waddr  = wr_addr;
            // x0 is hardwired: the cycle still happens, the write does not.
            rf_we     = (wr_addr != '0);
            wdata_sel = is_store;
            alu_sub   = is_sub;
         end
         S_DONE: begin
            busy       = 1'b1;
            rf_raddr1  = rs1_q;
            rf_raddr2  = rs2_q;
            op_done    = 1'b1;
            illegal_op = !op_legal;
         end
         default: ;
      endcase
   end

   assign imm_out     = imm_q;
   assign retired_cnt = cnt_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Directed bench for proc_ctrl_fsm: reset, ADD/SUB/STORE/NOP/illegal sequences,
// x0 write suppression, reset mid-operation and counter saturation.
module tb_proc_ctrl_fsm;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              instr_valid;
   logic [6:0]        op_code;
   logic [ADDR_W-1:0] rs1, rs2, rd;
   logic [DATA_W-1:0] imm;

   logic              instr_ready, rf_we, wdata_sel, alu_sub, busy, op_done, illegal_op;
   logic [ADDR_W-1:0] rf_raddr1, rf_raddr2, rf_waddr;
   logic [DATA_W-1:0] imm_out;
   logic [15:0]       retired_cnt;
   logic [2:0]        dbg_state;

   logic              s_instr_ready, s_rf_we, s_wdata_sel, s_alu_sub, s_busy, s_op_done, s_illegal_op;
   logic [ADDR_W-1:0] s_rf_raddr1, s_rf_raddr2, s_rf_waddr;
   logic [DATA_W-1:0] s_imm_out;
   logic [2:0]        s_retired_cnt;
   logic [2:0]        s_dbg_state;

   int checks = 0;
   int errors = 0;

   proc_ctrl_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .op_code(op_code), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
      .wdata_sel(wdata_sel), .alu_sub(alu_sub), .imm_out(imm_out), .busy(busy),
      .op_done(op_done), .illegal_op(illegal_op), .retired_cnt(retired_cnt),
      .dbg_state(dbg_state)
   );

   // Narrow-counter instance for the saturation case; shares all stimulus.
   proc_ctrl_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(s_instr_ready),
      .op_code(op_code), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .rf_raddr1(s_rf_raddr1), .rf_raddr2(s_rf_raddr2), .rf_waddr(s_rf_waddr), .rf_we(s_rf_we),
      .wdata_sel(s_wdata_sel), .alu_sub(s_alu_sub), .imm_out(s_imm_out), .busy(s_busy),
      .op_done(s_op_done), .illegal_op(s_illegal_op), .retired_cnt(s_retired_cnt),
      .dbg_state(s_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge, outputs are sampled there too.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic send(input logic [6:0] op, input logic [ADDR_W-1:0] a,
                       input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] d,
                       input logic [DATA_W-1:0] im);
      op_code     = op;
      rs1         = a;
      rs2         = b;
      rd          = d;
      imm         = im;
      instr_valid = 1'b1;
   endtask

   logic saw_we, saw_done;

   initial begin
      rst_n = 1'b0;
      send(7'd2, 5'd2, 5'd3, 5'd10, 32'h0);

      // reset held two edges with instr_valid high
      repeat (2) cyc();
      chk("rst_ready", instr_ready, 1);
      chk("rst_state", dbg_state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_we", rf_we, 0);
      chk("rst_done", op_done, 0);
      chk("rst_cnt", retired_cnt, 0);
      chk("rst_imm", imm_out, 0);
      chk("rst_raddr1", rf_raddr1, 0);

      // ADD accepted on the first edge after release
      rst_n = 1'b1;
      cyc();
      instr_valid = 1'b0;
      chk("add_c1_state", dbg_state, 1);
      chk("add_c1_ready", instr_ready, 0);
      chk("add_c1_busy", busy, 1);
      chk("add_c1_raddr1", rf_raddr1, 2);
      chk("add_c1_raddr2", rf_raddr2, 3);
      chk("add_c1_we", rf_we, 0);
      cyc();
      chk("add_c2_alu_sub", alu_sub, 0);
      chk("add_c2_we", rf_we, 0);
      chk("add_c2_raddr1", rf_raddr1, 2);
      cyc();
      chk("add_c3_we", rf_we, 1);
      chk("add_c3_waddr", rf_waddr, 10);
      chk("add_c3_wsel", wdata_sel, 0);
      chk("add_c3_alu_sub", alu_sub, 0);
      chk("add_c3_done", op_done, 0);
      cyc();
      chk("add_c4_done", op_done, 1);
      chk("add_c4_illegal", illegal_op, 0);
      chk("add_c4_we", rf_we, 0);
      chk("add_c4_raddr2", rf_raddr2, 3);
      cyc();
      chk("add_c5_state", dbg_state, 0);
      chk("add_c5_done", op_done, 0);
      chk("add_cnt", retired_cnt, 1);

      // SUB, then STORE presented early and held until accepted
      send(7'd3, 5'd4, 5'd5, 5'd14, 32'h0);
      cyc();
      chk("sub_c1_raddr1", rf_raddr1, 4);
      chk("sub_c1_raddr2", rf_raddr2, 5);
      cyc();
      chk("sub_c2_alu_sub", alu_sub, 1);
      chk("sub_c2_we", rf_we, 0);
      send(7'd1, 5'd7, 5'd0, 5'd0, 32'hDEADBEEF);
      cyc();
      chk("sub_c3_we", rf_we, 1);
      chk("sub_c3_waddr", rf_waddr, 14);
      chk("sub_c3_alu_sub", alu_sub, 1);
      chk("sub_c3_wsel", wdata_sel, 0);
      chk("sub_c3_imm_held", imm_out, 0);
      cyc();
      chk("sub_c4_done", op_done, 1);
      cyc();
      chk("sub_c5_ready", instr_ready, 1);
      chk("sub_cnt", retired_cnt, 2);
      cyc();
      instr_valid = 1'b0;
      chk("st_c6_state", dbg_state, 3);
      chk("st_c6_we", rf_we, 1);
      chk("st_c6_waddr", rf_waddr, 7);
      chk("st_c6_wsel", wdata_sel, 1);
      chk("st_c6_imm", imm_out, 32'hDEADBEEF);
      chk("st_c6_alu_sub", alu_sub, 0);
      cyc();
      chk("st_c7_done", op_done, 1);
      chk("st_c7_we", rf_we, 0);
      cyc();
      chk("st_cnt", retired_cnt, 3);

      // NOP
      send(7'd0, 5'd1, 5'd1, 5'd1, 32'h1);
      cyc();
      instr_valid = 1'b0;
      chk("nop_done", op_done, 1);
      chk("nop_illegal", illegal_op, 0);
      chk("nop_we", rf_we, 0);
      cyc();
      chk("nop_cnt", retired_cnt, 4);

      // illegal 0x05
      send(7'h05, 5'd1, 5'd1, 5'd1, 32'h1);
      cyc();
      instr_valid = 1'b0;
      chk("ill5_done", op_done, 1);
      chk("ill5_illegal", illegal_op, 1);
      chk("ill5_we", rf_we, 0);
      cyc();
      chk("ill5_state", dbg_state, 0);
      chk("ill5_cnt", retired_cnt, 4);

      // illegal 0x42: low bits look like ADD, upper bit set
      send(7'h42, 5'd1, 5'd2, 5'd3, 32'h0);
      cyc();
      instr_valid = 1'b0;
      chk("ill42_state", dbg_state, 4);
      chk("ill42_illegal", illegal_op, 1);
      cyc();
      chk("ill42_cnt", retired_cnt, 4);

      // ADD to x0: write suppressed, sequence still runs
      send(7'd2, 5'd1, 5'd1, 5'd0, 32'h0);
      cyc();
      instr_valid = 1'b0;
      cyc();
      cyc();
      chk("x0_c3_state", dbg_state, 3);
      chk("x0_c3_we", rf_we, 0);
      cyc();
      chk("x0_c4_done", op_done, 1);
      cyc();
      chk("x0_cnt", retired_cnt, 5);

      // reset mid-operation during EXEC
      send(7'd2, 5'd6, 5'd8, 5'd9, 32'h0);
      cyc();
      instr_valid = 1'b0;
      cyc();
      chk("midrst_exec", dbg_state, 2);
      rst_n = 1'b0;
      cyc();
      chk("midrst_state", dbg_state, 0);
      chk("midrst_cnt", retired_cnt, 0);
      chk("midrst_imm", imm_out, 0);
      rst_n    = 1'b1;
      saw_we   = rf_we;
      saw_done = op_done;
      for (int i = 0; i < 4; i++) begin
         cyc();
         saw_we   = saw_we | rf_we;
         saw_done = saw_done | op_done;
      end
      chk("midrst_no_we", saw_we, 0);
      chk("midrst_no_done", saw_done, 0);
      chk("midrst_idle", dbg_state, 0);

      // saturation: 9 NOPs
      for (int i = 0; i < 9; i++) begin
         send(7'd0, 5'd0, 5'd0, 5'd0, 32'h0);
         cyc();
         instr_valid = 1'b0;
         cyc();
         if (i == 6) chk("sat_at7", s_retired_cnt, 7);
      end
      chk("sat_stuck", s_retired_cnt, 7);
      chk("sat_wide_cnt", retired_cnt, 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
